// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: big-endian words written from address 0.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CSUM
`endif
  } state_t;

  state_t state;
  state_t state_n;
  state_t fin_st;

  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [ADDR_W:0] idx;
  logic [1:0]    bcnt;
  logic [31:0]   word;

  logic          xfer;
  logic          idle_like;
  logic          start_ok;
  logic [15:0]   n_new;
  logic [15:0]   idx_nx;
  logic          last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum;
  logic [7:0]    sum_nx;
  assign sum_nx = sum + rx_data;
  assign fin_st = S_CSUM;
`else
  assign fin_st = S_DONE;
`endif

  assign idle_like = (state == S_IDLE) ||
                     (state == S_DONE) ||
                     (state == S_ERR);
  assign start_ok  = start && idle_like;
  assign xfer      = rx_valid && rx_ready;
  assign n_new     = {len_hi, rx_data};
  // 16-bit compare keeps N == DEPTH legal without wrapping idx
  assign idx_nx    = 16'(idx) + 16'd1;
  assign last_word = (idx_nx == len);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) state_n = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, n_new} > DEPTH)
            state_n = S_ERR;
          else if (n_new == 16'd0)
            state_n = fin_st;
          else
            state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && (bcnt == 2'd3)) state_n = S_WRITE;
      end
      S_WRITE: begin
        state_n = last_word ? fin_st : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_n = (sum_nx == 8'h00) ? S_DONE : S_ERR;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      len_hi <= '0;
      len    <= '0;
      idx    <= '0;
      bcnt   <= '0;
      word   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum    <= '0;
`endif
    end else begin
      state <= state_n;
      if (start_ok) begin
        idx  <= '0;
        bcnt <= '0;
        word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum  <= '0;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer) sum <= sum_nx;
`endif
      if (xfer && (state == S_LEN_HI)) len_hi <= rx_data;
      if (xfer && (state == S_LEN_LO)) len <= n_new;
      if (xfer && (state == S_DATA)) begin
        word <= {word[23:0], rx_data};
        bcnt <= bcnt + 2'd1;
      end
      if (state == S_WRITE) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    rx_ready = (state == S_LEN_HI) ||
               (state == S_LEN_LO) ||
               (state == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == S_CSUM) rx_ready = 1'b1;
`endif
  end

  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = imem_we ? idx[ADDR_W-1:0] : '0;
  assign imem_wdata = imem_we ? word : '0;
  assign busy       = !idle_like;
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign cpu_hold   = busy || err;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them sequentially from word address 0 through a single write port, holding the CPU pipeline while a load is in progress. It sits between a host byte source (UART receiver or testbench) and the instruction ROM's write port; the fetch path keeps reading the same array by PC.

## Interface
- ADDR_W, 8, word-address width; DEPTH = 2^ADDR_W words (256)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  single-cycle pulse; begins a load session (honoured only in IDLE/DONE/ERR)
- rx_valid  in  1  byte source has rx_data valid
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte this cycle; transfer when rx_valid && rx_ready
- imem_we  out  1  one-cycle write strobe to instruction memory
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word to write
- cpu_hold  out  1  holds CPU pipeline in reset while high
- busy  out  1  session in progress (any state other than IDLE/DONE/ERR)
- done  out  1  load finished successfully; level, held until next start or reset
- err  out  1  load aborted; level, held until next start or reset

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 payload bytes, each word MSB first (first byte -> bits 31:24).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN_HI. Clear done/err, set cpu_hold, reset word index and byte counter.
- LEN_HI: accept byte -> LEN_LO.
- LEN_LO: accept byte -> N is complete.
  - N > DEPTH -> ERR.
  - N == 0 -> DONE (CSUM if macro enabled).
  - Otherwise -> DATA.
- DATA: shift bytes into a 32-bit assembly register. After the 4th byte -> WRITE.
- WRITE: imem_we=1, imem_addr=word index, imem_wdata=assembled word. Increment the index.
  - More words pending -> DATA.
  - Last word -> DONE (CSUM if macro enabled).
- DONE: done=1, cpu_hold=0. ERR: err=1, cpu_hold stays 1.
- rx_ready = 1 only in LEN_HI, LEN_LO, DATA, CSUM. It is 0 in IDLE, WRITE, DONE, ERR.
- start in any busy state is ignored.
- N == DEPTH is legal: the last write goes to address DEPTH-1, and the index does not wrap.
- Word index is ADDR_W+1 bits wide internally. The comparison against N uses 16-bit unsigned arithmetic.

## Timing
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, busy=0, done=0, err=0.
- All outputs are registered or decoded from registered state. No combinational path from rx_valid to rx_ready.
- start in cycle T -> LEN_HI and rx_ready=1 in T+1.
- 4th byte of a word accepted in cycle T -> imem_we=1 with addr/data valid in T+1 -> rx_ready=1 again in T+2.
- Back-to-back stream: 5 cycles per word.
- Final write (or LEN_LO with N=0) in T -> done=1, busy=0, cpu_hold=0 in T+1.
- Gaps in rx_valid stall the FSM with no state change. rx_data is ignored when rx_valid=0.
- reset mid-session: next cycle IDLE with reset values. Words already written remain in memory.
- reset and start in the same cycle: reset wins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last word (or after LEN_LO when N=0), CSUM state accepts one byte.
  - The 8-bit sum of all stream bytes (LEN_HI through the checksum byte) must equal 0x00 mod 256.
  - Match -> DONE; mismatch -> ERR.
  - Writes already issued are not undone.
- Undefined: no CSUM state, no checksum byte, no sum accumulator. Last write goes directly to DONE.

## Test plan
- Load 3 words: start, then bytes 00 03 20 01 00 04 20 22 00 02 00 01 18 20 with rx_valid held high.
  - Required: imem_we pulses at addr 0/1/2 with data 0x20010004, 0x20220002, 0x00011820, 5 cycles apart.
  - Required: done=1, cpu_hold=0 one cycle after the third write.
- Backpressure: same stream with rx_valid low on alternate cycles.
  - Required: identical writes, no duplicated or dropped bytes, rx_ready never 1 during WRITE.
- Oversize: ADDR_W=8, length bytes 01 01 (N=257).
  - Required: err=1 and cpu_hold=1 after LEN_LO, no imem_we pulse, rx_ready=0.
- Zero length: bytes 00 00.
  - Required: done=1 next cycle, no writes.
  - With IMEM_LOADER_CHECKSUM_EN: checksum byte 00 is required first.
- Reset mid-load: reset asserted after 6 payload bytes.
  - Required: next cycle all outputs at reset values, state IDLE.
  - Required: a subsequent start plus full stream completes normally from addr 0.
- With IMEM_LOADER_CHECKSUM_EN, stream 00 01 00 00 00 05 + checksum FA -> done=1. Same stream + checksum FB -> err=1, the one write to addr 0 is still issued.
